// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART receiver types, oversampling constants and divider math.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 7;
    localparam int unsigned DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        int unsigned d;
        d = clk_freq / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : First-word-fall-through FIFO with extra-MSB pointers; a push while
//           full is accepted only when a pop happens in the same cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_wr_en;
    logic             w_rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign w_rd_en = pop_i & ~empty_o;
    // When full, the slot being written is the one vacated by the same-cycle pop.
    assign w_wr_en = push_i & (~full_o | w_rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= din_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (w_rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : 16x-oversampled 8N1 UART receiver feeding a FWFT byte FIFO, with
//           framing-error and overrun pulses. Define UART_RX_PARITY_EN to
//           add an even-parity bit between data and stop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       rd_en_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int unsigned     DIV       = calc_div(CLK_FREQ, BAUD);
    localparam int              CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIV - 1);

    state_e           state_q, state_d;
    logic             meta_q, rxs_q;
    logic [CNT_W-1:0] tcnt_q;
    logic [3:0]       sc_q, sc_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             push_q, push_d;
    logic             ferr_q, ferr_d;
    logic             w_tick, w_mid, w_bit_end, w_tcnt_clr;
    logic             w_pop, w_full, w_empty;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
    logic             w_par_bad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= rxd;
            rxs_q  <= meta_q;
        end
    end

    assign w_tick    = (tcnt_q == TICK_LAST);
    assign w_mid     = w_tick && (sc_q == 4'(MID_SAMPLE));
    assign w_bit_end = w_tick && (sc_q == 4'(OVERSAMPLE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
        end else if (w_tcnt_clr || w_tick) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rxs_q) state_d = ST_START;
            ST_START: if (w_mid) state_d = rxs_q ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (w_bit_end && idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (w_bit_end) state_d = ST_STOP;
`endif
            ST_STOP:  if (w_bit_end) state_d = rxs_q ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_bad = ^{shift_q, par_q};
`endif

    always_comb begin
        sc_d       = w_tick ? sc_q + 4'd1 : sc_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push_d     = 1'b0;
        ferr_d     = 1'b0;
        w_tcnt_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        perr_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    sc_d       = 4'd0;
                    w_tcnt_clr = 1'b1;
                end
            end
            ST_START: begin
                if (w_mid && !rxs_q) begin
                    sc_d  = 4'd0;
                    idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) par_d = rxs_q;
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    ferr_d = ~rxs_q;
`ifdef UART_RX_PARITY_EN
                    perr_d = w_par_bad;
                    push_d = rxs_q & ~w_par_bad;
`else
                    push_d = rxs_q;
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc_q    <= 4'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sc_q    <= sc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // shift_q stays stable through the push cycle: the next frame cannot reach DATA yet.
    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .pop_i   (w_pop),
        .din_i   (shift_q),
        .dout_o  (data_o),
        .empty_o (w_empty),
        .full_o  (w_full)
    );

    assign valid_o     = ~w_empty;
    assign w_pop       = rd_en_i & valid_o;
    assign overrun_o   = push_q & w_full & ~w_pop;
    assign frame_err_o = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed, table-driven bench for uart_rx_fifo at 16 clk per bit.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ   = 1600000;
    localparam int unsigned BAUD       = 100000;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PEXTRA = 16;
`else
    localparam int PEXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rd_en_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o, parity_err_o;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0, n_ovr = 0, n_perr = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .rd_en_i      (rd_en_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o),
        .parity_err_o (parity_err_o)
    );

    always @(negedge clk) begin
        if (frame_err_o)  n_ferr++;
        if (overrun_o)    n_ovr++;
        if (parity_err_o) n_perr++;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_bit;
        logic       exp_valid;
        logic [7:0] exp_d;
        int         exp_ferr;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_wait();
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        logic pb;
        pb  = (^d) ^ par_flip;
        rxd = 1'b0;
        bit_wait();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            bit_wait();
        end
`ifdef UART_RX_PARITY_EN
        rxd = pb;
        bit_wait();
`endif
        rxd = stop_bit;
        bit_wait();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int maxc, output int lat);
        lat = 0;
        while (!valid_o && lat < maxc) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop();
        rd_en_i = 1'b1;
        @(posedge clk);
        #1;
        rd_en_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        int lat, f0, o0, p0;

        vt[0] = '{d: 8'h00, stop_bit: 1'b1, exp_valid: 1'b1, exp_d: 8'h00, exp_ferr: 0};
        vt[1] = '{d: 8'hFF, stop_bit: 1'b1, exp_valid: 1'b1, exp_d: 8'hFF, exp_ferr: 0};
        vt[2] = '{d: 8'h5A, stop_bit: 1'b1, exp_valid: 1'b1, exp_d: 8'h5A, exp_ferr: 0};
        vt[3] = '{d: 8'h81, stop_bit: 1'b0, exp_valid: 1'b0, exp_d: 8'h00, exp_ferr: 1};
        vt[4] = '{d: 8'h96, stop_bit: 1'b1, exp_valid: 1'b1, exp_d: 8'h96, exp_ferr: 0};

        // reset state
        idle(3);
        chk("rst_valid", 32'(valid_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_ovr", 32'(overrun_o), 0);
        chk("rst_perr", 32'(parity_err_o), 0);
        rst = 1'b0;
        idle(5);

        // single byte with latency
        lat = 0;
        fork
            send_byte(8'hA5, 1'b1, 1'b0);
            wait_valid(200 + PEXTRA, lat);
        join
        chk("a5_latency_ok", 32'(lat >= 148 + PEXTRA && lat <= 162 + PEXTRA), 1);
        chk("a5_valid", 32'(valid_o), 1);
        chk("a5_data", 32'(data_o), 32'h A5);
        pop();
        chk("a5_after_pop", 32'(valid_o), 0);

        // short glitch
        f0 = n_ferr; p0 = n_perr;
        rxd = 1'b0;
        idle(6);
        rxd = 1'b1;
        idle(40);
        chk("glitch_valid", 32'(valid_o), 0);
        chk("glitch_ferr", 32'(n_ferr - f0), 0);
        chk("glitch_perr", 32'(n_perr - p0), 0);

        // table-driven single frames
        for (int i = 0; i < 5; i++) begin
            f0 = n_ferr;
            send_byte(vt[i].d, vt[i].stop_bit, 1'b0);
            rxd = 1'b1;
            wait_valid(40, lat);
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vt[i].exp_valid));
            if (vt[i].exp_valid) begin
                chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(vt[i].exp_d));
                pop();
            end
            idle(20);
            chk($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vt[i].exp_ferr));
            chk($sformatf("vec%0d_empty", i), 32'(valid_o), 0);
        end

        // five back-to-back bytes, no pops
        o0 = n_ovr;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1, 1'b0);
        idle(20);
        chk("ovr_once", 32'(n_ovr - o0), 1);
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("ovr_order%0d", b), 32'(data_o), 32'(b));
            pop();
        end
        chk("ovr_drained", 32'(valid_o), 0);

        // full FIFO, pop in the exact push cycle
        for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b), 1'b1, 1'b0);
        o0 = n_ovr;
        fork
            send_byte(8'h15, 1'b1, 1'b0);
            begin
                repeat (155 + PEXTRA) @(posedge clk);
                #1 rd_en_i = 1'b1;
                @(posedge clk);
                #1 rd_en_i = 1'b0;
            end
        join
        idle(10);
        chk("pushpop_no_ovr", 32'(n_ovr - o0), 0);
        for (int b = 8'h12; b <= 8'h15; b++) begin
            chk($sformatf("pushpop_valid%0h", b), 32'(valid_o), 1);
            chk($sformatf("pushpop_data%0h", b), 32'(data_o), 32'(b));
            pop();
        end
        chk("pushpop_count4", 32'(valid_o), 0);

        // bad stop, held break, then a good byte
        f0 = n_ferr;
        send_byte(8'h3C, 1'b0, 1'b0);
        idle(40);
        rxd = 1'b1;
        idle(20);
        send_byte(8'h7E, 1'b1, 1'b0);
        wait_valid(40, lat);
        chk("break_ferr_once", 32'(n_ferr - f0), 1);
        chk("break_data", 32'(data_o), 32'h7E);
        pop();
        chk("break_one_byte", 32'(valid_o), 0);

        // reset in the middle of DATA with two bytes queued
        send_byte(8'h21, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        idle(5);
        chk("rstmid_queued", 32'(valid_o), 1);
        f0 = n_ferr; p0 = n_perr;
        rxd = 1'b0; bit_wait();
        rxd = 1'b1; bit_wait();
        rxd = 1'b0; bit_wait();
        rst = 1'b1;
        #1;
        chk("rstmid_valid", 32'(valid_o), 0);
        chk("rstmid_data", 32'(data_o), 0);
        rxd = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        chk("rstmid_ferr", 32'(n_ferr - f0), 0);
        chk("rstmid_perr", 32'(n_perr - p0), 0);
        chk("rstmid_empty", 32'(valid_o), 0);
        send_byte(8'h11, 1'b1, 1'b0);
        wait_valid(40, lat);
        chk("rstmid_next", 32'(data_o), 32'h11);
        pop();

`ifdef UART_RX_PARITY_EN
        p0 = n_perr; f0 = n_ferr;
        send_byte(8'h03, 1'b1, 1'b1);
        idle(40);
        chk("par_err_once", 32'(n_perr - p0), 1);
        chk("par_no_ferr", 32'(n_ferr - f0), 0);
        chk("par_dropped", 32'(valid_o), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
